// File: rtl/vc_input_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : vc_input_buffer                                               |
// | Purpose  : Four-VC router input buffer. Each virtual channel owns a      |
// |            circular FIFO; the arbiter grant selects which head flit is   |
// |            presented downstream and popped on out_ready.                 |
// | Option   : VCBUF_CREDIT_RETURN_EN - when defined, every pop returns one  |
// |            credit upstream as a registered single-cycle pulse. When not  |
// |            defined, credit_valid/credit_vc are tied low.                 |
// | Ports    : clk, reset (async, active-high)                               |
// |            in_valid/in_vc/in_flit   - write side                         |
// |            grant (0-3 = VC, 4-7 idle), out_ready - read side control     |
// |            request, vc_full          - per-VC occupancy status           |
// |            out_valid/out_flit/out_vc - granted head flit                 |
// |            overflow                  - sticky write-to-full flag         |
// |            credit_valid/credit_vc    - credit return                     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module vc_input_buffer #(
  parameter int FLIT_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [1:0]        in_vc,
  input  logic [FLIT_W-1:0] in_flit,
  input  logic [2:0]        grant,
  input  logic              out_ready,
  output logic [3:0]        request,
  output logic [3:0]        vc_full,
  output logic              out_valid,
  output logic [FLIT_W-1:0] out_flit,
  output logic [1:0]        out_vc,
  output logic              overflow,
  output logic              credit_valid,
  output logic [1:0]        credit_vc
);

  localparam int C_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int C_CNT_W = C_PTR_W + 1;
  localparam logic [C_CNT_W-1:0] C_FULL_CNT = C_CNT_W'(DEPTH);

  // Flit storage is intentionally not reset; occupancy alone defines validity.
  logic [FLIT_W-1:0]  r_mem    [0:3][0:DEPTH-1];
  logic [C_PTR_W-1:0] r_rd_ptr [0:3];
  logic [C_PTR_W-1:0] r_wr_ptr [0:3];
  logic [C_CNT_W-1:0] r_cnt    [0:3];
  logic               r_overflow;

  logic [3:0]        w_req;
  logic [3:0]        w_full;
  logic [3:0]        w_wr_en;
  logic [3:0]        w_pop_en;
  logic [1:0]        w_gvc;
  logic              w_grant_act;
  logic              w_out_valid;
  logic              w_pop;
  logic [FLIT_W-1:0] w_head;

  assign w_gvc       = grant[1:0];
  // grant values 4-7 all mean idle, so bit 2 alone qualifies a real grant.
  assign w_grant_act = ~grant[2];
  assign w_out_valid = w_grant_act & w_req[w_gvc];
  assign w_pop       = w_out_valid & out_ready;
  assign w_head      = r_mem[w_gvc][r_rd_ptr[w_gvc]];

  generate
    for (genvar v = 0; v < 4; v++) begin : g_vc
      assign w_req[v]    = (r_cnt[v] != '0);
      assign w_full[v]   = (r_cnt[v] == C_FULL_CNT);
      // A full VC drops the write even if it is popped this cycle; fullness
      // is judged on the pre-edge count.
      assign w_wr_en[v]  = in_valid & (in_vc == 2'(v)) & ~w_full[v];
      assign w_pop_en[v] = w_pop & (w_gvc == 2'(v));
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        r_rd_ptr[i] <= '0;
        r_wr_ptr[i] <= '0;
        r_cnt[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_wr_en[i]) r_wr_ptr[i] <= r_wr_ptr[i] + C_PTR_W'(1);
        if (w_pop_en[i]) r_rd_ptr[i] <= r_rd_ptr[i] + C_PTR_W'(1);
        case ({w_wr_en[i], w_pop_en[i]})
          2'b10:   r_cnt[i] <= r_cnt[i] + C_CNT_W'(1);
          2'b01:   r_cnt[i] <= r_cnt[i] - C_CNT_W'(1);
          default: r_cnt[i] <= r_cnt[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (w_wr_en[i]) r_mem[i][r_wr_ptr[i]] <= in_flit;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (in_valid && w_full[in_vc]) begin
      r_overflow <= 1'b1;
    end
  end

`ifdef VCBUF_CREDIT_RETURN_EN
  logic       r_credit_valid;
  logic [1:0] r_credit_vc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_credit_valid <= 1'b0;
      r_credit_vc    <= 2'd0;
    end else begin
      r_credit_valid <= w_pop;
      r_credit_vc    <= w_pop ? w_gvc : 2'd0;
    end
  end

  assign credit_valid = r_credit_valid;
  assign credit_vc    = r_credit_vc;
`else
  assign credit_valid = 1'b0;
  assign credit_vc    = 2'd0;
`endif

  assign request   = w_req;
  assign vc_full   = w_full;
  assign out_valid = w_out_valid;
  assign out_flit  = w_out_valid ? w_head : '0;
  assign out_vc    = w_gvc;
  assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_vc_input_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_vc_input_buffer                                            |
// | Purpose  : Self-checking bench for vc_input_buffer. A queue-per-VC model |
// |            predicts every output; directed scenarios are followed by a   |
// |            randomized traffic phase. Honors VCBUF_CREDIT_RETURN_EN.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_vc_input_buffer;

  localparam int FLIT_W = 32;
  localparam int DEPTH  = 4;
`ifdef VCBUF_CREDIT_RETURN_EN
  localparam bit CREDIT_EN = 1'b1;
`else
  localparam bit CREDIT_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [1:0]        in_vc;
  logic [FLIT_W-1:0] in_flit;
  logic [2:0]        grant;
  logic              out_ready;
  logic [3:0]        request;
  logic [3:0]        vc_full;
  logic              out_valid;
  logic [FLIT_W-1:0] out_flit;
  logic [1:0]        out_vc;
  logic              overflow;
  logic              credit_valid;
  logic [1:0]        credit_vc;

  vc_input_buffer #(.FLIT_W(FLIT_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_vc        (in_vc),
    .in_flit      (in_flit),
    .grant        (grant),
    .out_ready    (out_ready),
    .request      (request),
    .vc_full      (vc_full),
    .out_valid    (out_valid),
    .out_flit     (out_flit),
    .out_vc       (out_vc),
    .overflow     (overflow),
    .credit_valid (credit_valid),
    .credit_vc    (credit_vc)
  );

  always #5 clk = ~clk;

  // Reference model: one FIFO queue per VC plus expected sticky/credit state.
  logic [FLIT_W-1:0] mq [4][$];
  bit                m_ovf;
  bit                m_cv;
  logic [1:0]        m_cvc;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) mq[i].delete();
    m_ovf = 1'b0;
    m_cv  = 1'b0;
    m_cvc = 2'd0;
  endtask

  // Compare all outputs against the model for the inputs currently applied.
  task automatic chk_all();
    logic [3:0]        er;
    logic [3:0]        ef;
    bit                ev;
    logic [FLIT_W-1:0] eflit;
    int                g;
    for (int i = 0; i < 4; i++) begin
      er[i] = (mq[i].size() != 0);
      ef[i] = (mq[i].size() == DEPTH);
    end
    g     = int'(grant[1:0]);
    ev    = (grant < 3'd4) && (mq[g].size() != 0);
    eflit = ev ? mq[g][0] : '0;
    chk("request",   32'(request),   32'(er));
    chk("vc_full",   32'(vc_full),   32'(ef));
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("out_flit",  out_flit,       eflit);
    chk("out_vc",    32'(out_vc),    32'(grant[1:0]));
    chk("overflow",  32'(overflow),  32'(m_ovf));
    chk("credit_valid", 32'(credit_valid), 32'(m_cv));
    if (m_cv || !CREDIT_EN) chk("credit_vc", 32'(credit_vc), 32'(m_cvc));
  endtask

  // One clock cycle: apply inputs, check, advance model, clock edge.
  task automatic step(input bit v, input logic [1:0] vc, input logic [FLIT_W-1:0] f,
                      input logic [2:0] g, input bit rdy);
    bit wr_ok;
    bit pop;
    int gi;
    in_valid  = v;
    in_vc     = vc;
    in_flit   = f;
    grant     = g;
    out_ready = rdy;
    #1;
    chk_all();
    gi    = int'(g[1:0]);
    pop   = (g < 3'd4) && (mq[gi].size() != 0) && rdy;
    wr_ok = v && (mq[int'(vc)].size() < DEPTH);
    if (v && !wr_ok) m_ovf = 1'b1;
    if (pop) void'(mq[gi].pop_front());
    if (wr_ok) mq[int'(vc)].push_back(f);
    m_cv  = CREDIT_EN && pop;
    m_cvc = (CREDIT_EN && pop) ? g[1:0] : 2'd0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_vc     = 2'd0;
    in_flit   = '0;
    grant     = 3'd4;
    out_ready = 1'b0;
    model_clear();

    // Reset state.
    #2;
    chk_all();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single flit through VC2.
    step(1'b1, 2'd2, 32'hA5A5A5A5, 3'd4, 1'b0);
    step(1'b0, 2'd0, 32'h0,        3'd2, 1'b1);
    step(1'b0, 2'd0, 32'h0,        3'd4, 1'b0);

    // Fill VC1, overflow on 5th write, drain in order.
    for (int i = 1; i <= 5; i++) step(1'b1, 2'd1, 32'(i), 3'd7, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 2'd0, 32'h0, 3'd1, 1'b1);
    step(1'b0, 2'd0, 32'h0, 3'd1, 1'b1);

    // Write to an empty VC while it is granted: no bypass.
    step(1'b1, 2'd3, 32'h0000_0033, 3'd3, 1'b1);
    step(1'b0, 2'd0, 32'h0,         3'd3, 1'b1);

    // VC0 at count 2, simultaneous write+pop across pointer wrap.
    step(1'b1, 2'd0, 32'h100, 3'd4, 1'b0);
    step(1'b1, 2'd0, 32'h101, 3'd4, 1'b0);
    for (int i = 2; i < 8; i++) step(1'b1, 2'd0, 32'h100 + 32'(i), 3'd0, 1'b1);
    step(1'b0, 2'd0, 32'h0, 3'd0, 1'b1);
    step(1'b0, 2'd0, 32'h0, 3'd0, 1'b1);

    // All VCs non-empty, idle grants do not pop.
    for (int i = 0; i < 4; i++) step(1'b1, 2'(i), 32'h200 + 32'(i), 3'd4, 1'b0);
    step(1'b0, 2'd0, 32'h0, 3'd7, 1'b1);
    step(1'b0, 2'd0, 32'h0, 3'd5, 1'b1);
    step(1'b0, 2'd0, 32'h0, 3'd6, 1'b1);

    // Pop VC3: credit pulse for one cycle (when enabled).
    step(1'b0, 2'd0, 32'h0, 3'd3, 1'b1);
    step(1'b0, 2'd0, 32'h0, 3'd4, 1'b0);
    step(1'b0, 2'd0, 32'h0, 3'd4, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)), $urandom(),
           3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0));
    end

    // Asynchronous reset mid-cycle while three VCs hold data.
    for (int i = 0; i < 4; i++) step(1'b0, 2'd0, 32'h0, 3'd0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 2'd0, 32'h0, 3'd1, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 2'd0, 32'h0, 3'd2, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 2'd0, 32'h0, 3'd3, 1'b1);
    step(1'b1, 2'd0, 32'h300, 3'd4, 1'b0);
    step(1'b1, 2'd1, 32'h301, 3'd4, 1'b0);
    step(1'b1, 2'd2, 32'h302, 3'd4, 1'b0);
    step(1'b0, 2'd0, 32'h0,   3'd4, 1'b0);
    chk("pre_rst_request", 32'(request), 32'h7);
    #2;
    reset = 1'b1;
    #1;
    model_clear();
    chk("rst_request_now", 32'(request), 32'h0);
    chk("rst_credit_now",  32'(credit_valid), 32'h0);
    chk_all();
    @(posedge clk);
    #1;
    chk("rst_credit_edge", 32'(credit_valid), 32'h0);
    chk_all();
    reset = 1'b0;

    // Buffer operates normally after reset.
    step(1'b1, 2'd1, 32'h400, 3'd4, 1'b0);
    step(1'b0, 2'd0, 32'h0,   3'd1, 1'b1);
    step(1'b0, 2'd0, 32'h0,   3'd4, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
